// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: start bit, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits. Back-to-back frames when the FIFO has data.
module uart_tx_fifo #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = 4;

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_fifo: DATA_W must be in 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop;

    state_e            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              bit_done, stop_done;

    assign tx_ready   = count_q < CNT_W'(FIFO_DEPTH);
    assign push       = tx_valid && tx_ready;
    assign bit_done   = baud_q == BAUD_W'(CLKS_PER_BIT - 1);
    assign stop_done  = (state_q == StStop) && bit_done && (idx_q == IDX_W'(STOP_BITS - 1));
    // Only the registered count gates the pop, so a word written this edge waits one cycle.
    assign pop        = (count_q != '0) && ((state_q == StIdle) || stop_done);
    assign fifo_count = count_q;
    assign busy       = state_q != StIdle;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            serial_out <= 1'b1;
        end else if (pop) begin
            shift_q    <= mem[rd_ptr_q];
            par_q      <= (^mem[rd_ptr_q]) ^ (PARITY == 2);
            state_q    <= StStart;
            baud_q     <= '0;
            idx_q      <= '0;
            serial_out <= 1'b0;
        end else if (state_q != StIdle) begin
            if (!bit_done) begin
                baud_q <= baud_q + BAUD_W'(1);
            end else begin
                baud_q <= '0;
                unique case (state_q)
                    StStart: begin
                        state_q    <= StData;
                        idx_q      <= '0;
                        serial_out <= shift_q[0];
                    end
                    StData: begin
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            idx_q <= '0;
                            if (PARITY != 0) begin
                                state_q    <= StPar;
                                serial_out <= par_q;
                            end else begin
                                state_q    <= StStop;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            shift_q    <= shift_q >> 1;
                            serial_out <= shift_q[1];
                        end
                    end
                    StPar: begin
                        state_q    <= StStop;
                        idx_q      <= '0;
                        serial_out <= 1'b1;
                    end
                    StStop: begin
                        // Reaching here at the last stop bit means the FIFO was empty.
                        if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                            state_q <= StIdle;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        serial_out <= 1'b1;
                    end
                    default: begin
                        state_q    <= StIdle;
                        serial_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations, scoreboard of pushed words
// checked bit-by-bit against a frame model as the serial line produces them.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data0, data1;
    logic [4:0] data2;
    logic       valid [3];
    logic       ready [3];
    logic       ser   [3];
    logic       bsy   [3];
    logic [2:0] cnt   [3];

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] sb_q [$];
    int         run_len  [3];
    int         last_run [3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .serial_out(ser[0]), .busy(bsy[0]), .fifo_count(cnt[0])
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .serial_out(ser[1]), .busy(bsy[1]), .fifo_count(cnt[1])
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(0), .DATA_W(5)) u2 (
        .clk(clk), .rst(rst), .tx_data(data2), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .serial_out(ser[2]), .busy(bsy[2]), .fifo_count(cnt[2])
    );

    // Length of the most recent uninterrupted busy run, in clock cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (bsy[i]) begin
                run_len[i] <= run_len[i] + 1;
            end else if (run_len[i] != 0) begin
                last_run[i] <= run_len[i];
                run_len[i]  <= 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dw_of(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int par_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic line(input int i);
        return ser[i];
    endfunction

    task automatic drive(input int i, input logic [8:0] w, input logic v);
        case (i)
            0:       data0 = w[7:0];
            1:       data1 = w[7:0];
            default: data2 = w[4:0];
        endcase
        valid[i] = v;
    endtask

    // Entered at the negedge where the start bit is first visible.
    task automatic check_frame(input int i, input logic [8:0] w);
        logic exp_bits [$];
        logic p;
        int   busy_low;
        busy_low = 0;
        p = 1'b0;
        exp_bits.push_back(1'b0);
        for (int b = 0; b < dw_of(i); b++) begin
            exp_bits.push_back(w[b]);
            p = p ^ w[b];
        end
        if (par_of(i) != 0) exp_bits.push_back((par_of(i) == 2) ? ~p : p);
        for (int s = 0; s < stop_of(i); s++) exp_bits.push_back(1'b1);
        foreach (exp_bits[j]) begin
            logic obs;
            obs = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                if (c == 0 || line(i) !== exp_bits[j]) obs = line(i);
                if (bsy[i] !== 1'b1) busy_low++;
                @(negedge clk);
            end
            check_eq($sformatf("u%0d w%0h bit%0d", i, w, j), obs, exp_bits[j]);
        end
        check_eq($sformatf("u%0d w%0h busy_low", i, w), busy_low, 0);
    endtask

    task automatic expect_frames(input int i, input int n, input bit contig);
        for (int k = 0; k < n; k++) begin
            int         waited;
            logic [8:0] w;
            waited = 0;
            while (line(i) !== 1'b0 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 200) begin
                check_eq($sformatf("u%0d start_bound", i), line(i), 0);
                return;
            end
            if (contig && k > 0) check_eq($sformatf("u%0d gap%0d", i, k), waited, 0);
            if (sb_q.size() == 0) begin
                check_eq($sformatf("u%0d sb_underflow", i), sb_q.size(), 1);
                return;
            end
            w = sb_q.pop_front();
            check_frame(i, w);
        end
    endtask

    task automatic single_frame(input int i, input logic [8:0] w, input int exp_len);
        drive(i, w, 1'b1);
        check_eq($sformatf("u%0d ready_pre", i), ready[i], 1);
        sb_q.push_back(w);
        @(negedge clk);
        drive(i, w, 1'b0);
        check_eq($sformatf("u%0d lat_line_hi", i), line(i), 1);
        check_eq($sformatf("u%0d lat_count1", i), cnt[i], 1);
        check_eq($sformatf("u%0d lat_busy0", i), bsy[i], 0);
        @(negedge clk);
        check_eq($sformatf("u%0d lat_start", i), line(i), 0);
        check_eq($sformatf("u%0d lat_count0", i), cnt[i], 0);
        expect_frames(i, 1, 1'b0);
        check_eq($sformatf("u%0d end_line", i), line(i), 1);
        check_eq($sformatf("u%0d end_busy", i), bsy[i], 0);
        @(negedge clk);
        check_eq($sformatf("u%0d frame_len", i), last_run[i], exp_len);
    endtask

    // Expects an idle FSM and empty FIFO on entry; models the count edge by edge.
    task automatic burst(input int i, input logic [8:0] ws [8], input int n);
        int mcnt;
        bit midle, exp_rdy, mpop;
        mcnt  = 0;
        midle = 1'b1;
        for (int k = 0; k < n; k++) begin
            drive(i, ws[k], 1'b1);
            exp_rdy = (mcnt < DEPTH);
            check_eq($sformatf("u%0d burst ready%0d", i, k), ready[i], exp_rdy);
            if (exp_rdy) sb_q.push_back(ws[k]);
            @(negedge clk);
            mpop = midle && (mcnt > 0);
            if (mpop) midle = 1'b0;
            mcnt = mcnt + int'(exp_rdy) - int'(mpop);
            check_eq($sformatf("u%0d burst count%0d", i, k), cnt[i], mcnt);
        end
        drive(i, 9'h000, 1'b0);
    endtask

    initial begin
        logic [8:0] ws [8];
        for (int i = 0; i < 3; i++) begin
            valid[i]    = 1'b0;
            run_len[i]  = 0;
            last_run[i] = 0;
        end
        data0 = '0;
        data1 = '0;
        data2 = '0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Before any clock edge: reset must already be in effect.
        check_eq("rst line", ser[0], 1);
        check_eq("rst busy", bsy[0], 0);
        check_eq("rst ready", ready[0], 1);
        check_eq("rst count", cnt[0], 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        single_frame(0, 9'h0A5, 44);

        ws = '{9'h03A, 9'h0C5, 9'h00F, 9'h0F0, 9'h081, 9'h077, 9'h000, 9'h000};
        fork
            burst(0, ws, 6);
            expect_frames(0, 5, 1'b1);
        join
        check_eq("burst drained count", cnt[0], 0);
        check_eq("burst drained line", ser[0], 1);
        check_eq("burst sb empty", sb_q.size(), 0);

        ws = '{9'h011, 9'h022, 9'h0E7, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        fork
            burst(0, ws, 3);
            expect_frames(0, 3, 1'b1);
        join
        check_eq("wrap1 count", cnt[0], 0);
        ws = '{9'h09C, 9'h063, 9'h0AA, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        fork
            burst(0, ws, 3);
            expect_frames(0, 3, 1'b1);
        join
        check_eq("wrap2 count", cnt[0], 0);
        check_eq("wrap2 sb empty", sb_q.size(), 0);

        // Reset in cycle 10 of a frame (data bit 1 of 0x55, a zero) with one word queued.
        drive(0, 9'h055, 1'b1);
        @(negedge clk);
        drive(0, 9'h066, 1'b1);
        @(negedge clk);
        drive(0, 9'h000, 1'b0);
        repeat (9) @(negedge clk);
        check_eq("pre_rst line", ser[0], 0);
        check_eq("pre_rst count", cnt[0], 1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst line", ser[0], 1);
        check_eq("mid_rst busy", bsy[0], 0);
        check_eq("mid_rst count", cnt[0], 0);
        check_eq("mid_rst ready", ready[0], 1);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        single_frame(0, 9'h03C, 44);

        single_frame(1, 9'h001, 48);
        single_frame(2, 9'h01F, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
- Parameters (name, default, meaning):
  - REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame; legal range 5..9.
  - REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; minimum 2.
  - REQ-003 The block SHALL have parameter PARITY, default 1, selecting parity: 0 none, 1 even, 2 odd.
  - REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; 1 or 2.
  - REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, giving transmit buffer entries; power of two, at least 2.
- Ports (name, direction, width, meaning):
  - REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
  - REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
  - REQ-008 The block SHALL have port tx_data, input, DATA_W bits: word to transmit.
  - REQ-009 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
  - REQ-010 The block SHALL have port tx_ready, output, 1 bit: the FIFO can accept a word.
  - REQ-011 The block SHALL have port serial_out, output, 1 bit: serial line, registered, idle high.
  - REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
  - REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of words held in the FIFO.

Function
- REQ-014 A word SHALL be pushed on a rising edge where tx_valid && tx_ready; tx_ready SHALL equal (fifo_count < FIFO_DEPTH), combinationally.
- REQ-015 tx_valid while tx_ready is low SHALL be ignored, with no FIFO change and no error state.
- REQ-016 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
- REQ-017 In IDLE with fifo_count > 0, the FSM SHALL pop the head word into a shift register and enter START on the same edge.
- REQ-018 serial_out SHALL be 0 in START, data bits LSB first in DATA, the parity bit in PAR, and 1 in STOP and IDLE.
- REQ-019 Every state except IDLE SHALL last exactly CLKS_PER_BIT cycles per bit, timed by a baud counter cleared on each state or bit change.
- REQ-020 DATA SHALL last DATA_W bit times; the PAR state SHALL be skipped when PARITY = 0; STOP SHALL last STOP_BITS bit times.
- REQ-021 The parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
- REQ-022 At the end of STOP, the FSM SHALL go directly to START if the FIFO is non-empty, with no idle gap and the pop on the same edge; otherwise it SHALL go to IDLE.
- REQ-023 Latency: a word pushed at edge k into an empty FIFO with the FSM in IDLE SHALL drive serial_out to 0 from edge k+1.
- REQ-024 On a simultaneous push and pop, fifo_count SHALL be unchanged and FIFO order SHALL be preserved.
- REQ-025 A push into an empty FIFO SHALL NOT be poppable in the same cycle.
- REQ-026 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-027 Frame length SHALL be (1 + DATA_W + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- REQ-028 Illegal parameter values SHALL be rejected at elaboration.

Reset
- REQ-029 While rst is high, serial_out SHALL be 1, busy 0, tx_ready 1, fifo_count 0, the FSM IDLE, and all counters 0, taking effect immediately without waiting for clk.
- REQ-030 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; the line SHALL return high at once.
- REQ-031 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
- REQ-032 Bench with defaults and CLKS_PER_BIT = 4: push 0xA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total, busy high throughout.
- REQ-033 Bench with PARITY = 2 and STOP_BITS = 2: push 0x01 -> start 0, data 1,0,0,0,0,0,0,0, parity 0, stop 1,1; 48 cycles.
- REQ-034 Bench with FIFO_DEPTH = 4: push 5 words back-to-back -> tx_ready low after 5 accepts (the FSM holds 1 word, the FIFO holds 4), the 6th rejected; all frames contiguous with no idle bit between them, in push order.
- REQ-035 Bench with the FIFO in the full or wrapping region: push 3 words, drain, push 3 more -> pointer wrap exercised, output order matches push order, fifo_count returns to 0.
- REQ-036 Bench asserting rst at cycle 10 of a frame -> serial_out 1 within the same cycle, fifo_count 0, busy 0; a subsequent push of 0x3C transmits correctly.
- REQ-037 Bench with PARITY = 0 and DATA_W = 5: push 0x1F -> frame 0,1,1,1,1,1,1 with no parity bit; 28 cycles.
